// File: rtl/mips.sv
// Moore control unit for a multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Define MIPS_ILLEGAL_TRAP_EN to park unrecognised opcodes in a TRAP state instead of refetching.
module mips (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [6:0] saida,
    output logic       IorD,
    output logic       AluSrcA,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Branch,
    output logic [1:0] AluSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
`ifdef MIPS_ILLEGAL_TRAP_EN
        ,
        S_TRAP    = 4'd12
`endif
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [21:0] ctrl_q;

    // funct is decoded downstream from ALUOp; it is only tied off here.
    logic unused_funct;
    assign unused_funct = ^funct;

    // Control word layout: {saida, IorD, AluSrcA, IRWrite, PCWrite, RegDst,
    // MemtoReg, RegWrite, MemWrite, Branch, AluSrcB, ALUOp, PCSrc}.
    function automatic logic [21:0] ctrl_for(input state_t s);
        logic [6:0] seg;
        logic       iord, srca, irw, pcw, rdst, m2r, rw, mw, br;
        logic [1:0] srcb, aop, pcs;
        seg  = 7'b0000001;
        iord = 1'b0;
        srca = 1'b0;
        irw  = 1'b0;
        pcw  = 1'b0;
        rdst = 1'b0;
        m2r  = 1'b0;
        rw   = 1'b0;
        mw   = 1'b0;
        br   = 1'b0;
        srcb = 2'b00;
        aop  = 2'b00;
        pcs  = 2'b00;
        case (s)
            S_FETCH: begin
                seg  = 7'b1111110;
                irw  = 1'b1;
                pcw  = 1'b1;
                srcb = 2'b01;
            end
            S_DECODE: begin
                seg  = 7'b0110000;
                srcb = 2'b11;
            end
            S_MEMADR: begin
                seg  = 7'b1101101;
                srca = 1'b1;
                srcb = 2'b10;
            end
            S_MEMRD: begin
                seg  = 7'b1111001;
                iord = 1'b1;
            end
            S_MEMWB: begin
                seg  = 7'b0110011;
                m2r  = 1'b1;
                rw   = 1'b1;
            end
            S_MEMWR: begin
                seg  = 7'b1011011;
                iord = 1'b1;
                mw   = 1'b1;
            end
            S_EXECUTE: begin
                seg  = 7'b1011111;
                srca = 1'b1;
                aop  = 2'b10;
            end
            S_ALUWB: begin
                seg  = 7'b1110000;
                rdst = 1'b1;
                rw   = 1'b1;
            end
            S_BRANCH: begin
                seg  = 7'b1111111;
                srca = 1'b1;
                aop  = 2'b01;
                pcs  = 2'b01;
                br   = 1'b1;
            end
            S_ADDIEX: begin
                seg  = 7'b1111011;
                srca = 1'b1;
                srcb = 2'b10;
            end
            S_ADDIWB: begin
                seg  = 7'b1110111;
                rw   = 1'b1;
            end
            S_JUMP: begin
                seg  = 7'b0011111;
                pcw  = 1'b1;
                pcs  = 2'b10;
            end
`ifdef MIPS_ILLEGAL_TRAP_EN
            S_TRAP: begin
                seg  = 7'b1001111;
            end
`endif
            default: begin
            end
        endcase
        return {seg, iord, srca, irw, pcw, rdst, m2r, rw, mw, br, srcb, aop, pcs};
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
`ifdef MIPS_ILLEGAL_TRAP_EN
            S_TRAP:    state_d = S_TRAP;
`endif
            default:   state_d = S_FETCH;
        endcase
        // Reset overrides every transition, including mid-instruction.
        if (!reset) begin
            state_d = S_FETCH;
        end
    end

    // Outputs are registered from the next state, so they always match state_q.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        ctrl_q  <= ctrl_for(state_d);
    end

    assign saida    = ctrl_q[21:15];
    assign IorD     = ctrl_q[14];
    assign AluSrcA  = ctrl_q[13];
    assign IRWrite  = ctrl_q[12];
    assign PCWrite  = ctrl_q[11];
    assign RegDst   = ctrl_q[10];
    assign MemtoReg = ctrl_q[9];
    assign RegWrite = ctrl_q[8];
    assign MemWrite = ctrl_q[7];
    assign Branch   = ctrl_q[6];
    assign AluSrcB  = ctrl_q[5:4];
    assign ALUOp    = ctrl_q[3:2];
    assign PCSrc    = ctrl_q[1:0];

endmodule

// File: tb/tb_mips.sv
// Scoreboard bench for the mips control FSM: a driver pushes the expected state per cycle,
// a monitor on the falling edge compares every control output against a table model.
module tb_mips;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic [6:0] saida;
    logic       IorD, AluSrcA, IRWrite, PCWrite, RegDst, MemtoReg, RegWrite, MemWrite, Branch;
    logic [1:0] AluSrcB, ALUOp, PCSrc;

    int exp_q[$];
    int total = 0;
    int bad = 0;

    mips dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .saida(saida),
        .IorD(IorD), .AluSrcA(AluSrcA), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Branch(Branch), .AluSrcB(AluSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc)
    );

    always #5 clk = ~clk;

    // Expected control word for a state index, straight from the state table.
    function automatic logic [21:0] exp_vec(input int s);
        logic [6:0] seg;
        logic [8:0] bits; // IorD AluSrcA IRWrite PCWrite RegDst MemtoReg RegWrite MemWrite Branch
        logic [1:0] srcb, aop, pcs;
        bits = 9'b0; srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            0:  begin seg = 7'b1111110; bits = 9'b001100000; srcb = 2'b01; end
            1:  begin seg = 7'b0110000; srcb = 2'b11; end
            2:  begin seg = 7'b1101101; bits = 9'b010000000; srcb = 2'b10; end
            3:  begin seg = 7'b1111001; bits = 9'b100000000; end
            4:  begin seg = 7'b0110011; bits = 9'b000001100; end
            5:  begin seg = 7'b1011011; bits = 9'b100000010; end
            6:  begin seg = 7'b1011111; bits = 9'b010000000; aop = 2'b10; end
            7:  begin seg = 7'b1110000; bits = 9'b000010100; end
            8:  begin seg = 7'b1111111; bits = 9'b010000001; aop = 2'b01; pcs = 2'b01; end
            9:  begin seg = 7'b1111011; bits = 9'b010000000; srcb = 2'b10; end
            10: begin seg = 7'b1110111; bits = 9'b000000100; end
            11: begin seg = 7'b0011111; bits = 9'b000100000; pcs = 2'b10; end
            12: begin seg = 7'b1001111; end
            default: seg = 7'b0000001;
        endcase
        return {seg, bits, srcb, aop, pcs};
    endfunction

    // Monitor: one comparison per cycle whenever an expectation is pending.
    initial begin
        forever begin
            int s;
            logic [21:0] e;
            logic [21:0] a;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                e = exp_vec(s);
                a = {saida, IorD, AluSrcA, IRWrite, PCWrite, RegDst, MemtoReg, RegWrite,
                     MemWrite, Branch, AluSrcB, ALUOp, PCSrc};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL ctrl state=%0d actual=%b required=%b", s, a, e);
                end
                $display("cycle t=%0t state=%0d ctrl=%b", $time, s, a);
            end
        end
    end

    task automatic edge_expect(input int s);
        @(posedge clk);
        #1;
        exp_q.push_back(s);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        edge_expect(0);
        edge_expect(0);
        reset = 1'b1;
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    endfunction

    // Called with FETCH visible; abort_at = step index at which reset is asserted (0 = never).
    task automatic run_instr(input logic [5:0] op, input int abort_at);
        int  seq[$];
        bit  trap;
        trap = 1'b0;
        opcode = op;
        funct = 6'($urandom);
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b000100: seq = '{0, 1, 8};
            6'b001000: seq = '{0, 1, 9, 10};
            6'b000010: seq = '{0, 1, 11};
            default: begin
`ifdef MIPS_ILLEGAL_TRAP_EN
                seq = '{0, 1, 12};
                trap = 1'b1;
`else
                seq = '{0, 1};
`endif
            end
        endcase
        for (int i = 1; i < seq.size(); i++) begin
            if (i == abort_at) begin
                reset = 1'b0;
                edge_expect(0);
                reset = 1'b1;
                return;
            end
            edge_expect(seq[i]);
        end
        if (trap) begin
            edge_expect(12);
            edge_expect(12);
            reset = 1'b0;
            edge_expect(0);
            reset = 1'b1;
        end else begin
            edge_expect(0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] op;
        logic [5:0] ops [0:5];
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;

        do_reset();
        run_instr(6'b100011, 0);
        run_instr(6'b101011, 0);
        run_instr(6'b000000, 0);
        run_instr(6'b000100, 0);
        run_instr(6'b001000, 0);
        run_instr(6'b000010, 0);
        run_instr(6'b100011, 4);   // reset while in MEMRD
        run_instr(6'b111111, 0);
        run_instr(6'b000000, 2);   // reset while in DECODE

        for (int n = 0; n < 120; n++) begin
            int r;
            int ab;
            r = $urandom_range(0, 7);
            if (r < 6) begin
                op = ops[r];
            end else begin
                do op = 6'($urandom); while (is_legal(op));
            end
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0;
            run_instr(op, ab);
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips.md
Name: mips

Overview:
- Moore control-unit FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
- Sits between the instruction register and the datapath muxes and enables.
- Drives all datapath control strobes.
- Also drives a 7-segment pattern of the current state index (hex digit) for board debug.

Parameters:
- none (opcodes and state encodings are fixed constants)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- opcode  input  6  instr[31:26], sampled live
- funct  input  6  instr[5:0]; unused by this block; ALU decode is done downstream from ALUOp
- saida  output  7  7-segment pattern of state index, active-high, bit6..0 = segments a,b,c,d,e,f,g
- IorD  output  1  memory address select (1 = ALUOut)
- AluSrcA  output  1  ALU A select (1 = register A)
- IRWrite  output  1  instruction register load
- PCWrite  output  1  unconditional PC load
- RegDst  output  1  write register select (1 = rd)
- MemtoReg  output  1  writeback select (1 = memory data)
- RegWrite  output  1  register file write
- MemWrite  output  1  memory write
- Branch  output  1  conditional PC load (ANDed with Zero downstream)
- AluSrcB  output  2  ALU B select: 00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
- ALUOp  output  2  00 add, 01 sub, 10 use funct
- PCSrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target

Behaviour:
- Reset: at a clk rising edge with reset==0, the state becomes FETCH. Reset has priority over all transitions, including mid-instruction.
- Initial state before the first reset edge is undefined.
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- One state transition per clock. Outputs are a pure function of state (Moore), so there is zero combinational path from opcode to outputs.
- Every output not listed for a state is 0.
- States, with index, outputs, and next state:
  - 0 FETCH: IRWrite=1, PCWrite=1, AluSrcB=01, ALUOp=00. Next: DECODE.
  - 1 DECODE: AluSrcB=11. Next, by opcode: LW/SW -> MEMADR; RTYPE -> EXECUTE; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP; any other opcode -> FETCH.
  - 2 MEMADR: AluSrcA=1, AluSrcB=10. Next: MEMWR if opcode==SW, else MEMRD.
  - 3 MEMRD: IorD=1. Next: MEMWB.
  - 4 MEMWB: MemtoReg=1, RegWrite=1. Next: FETCH.
  - 5 MEMWR: IorD=1, MemWrite=1. Next: FETCH.
  - 6 EXECUTE: AluSrcA=1, AluSrcB=00, ALUOp=10. Next: ALUWB.
  - 7 ALUWB: RegDst=1, RegWrite=1. Next: FETCH.
  - 8 BRANCH: AluSrcA=1, ALUOp=01, PCSrc=01, Branch=1. Next: FETCH.
  - 9 ADDIEX: AluSrcA=1, AluSrcB=10. Next: ADDIWB.
  - 10 ADDIWB: RegWrite=1. Next: FETCH.
  - 11 JUMP: PCWrite=1, PCSrc=10. Next: FETCH.
- saida patterns by state index:
  - 0: 1111110
  - 1: 0110000
  - 2: 1101101
  - 3: 1111001
  - 4: 0110011
  - 5: 1011011
  - 6: 1011111
  - 7: 1110000
  - 8: 1111111
  - 9: 1111011
  - A: 1110111
  - b: 0011111
- Unused state codes: next state FETCH; outputs all 0; saida 0000001.
- Instruction latency: lw 5 cycles, sw/R/addi 4, beq/j 3.

Optional Feature:
- Macro: MIPS_ILLEGAL_TRAP_EN
- Defined: DECODE with an unrecognised opcode goes to state 12 TRAP.
  - TRAP holds all controls at 0 and shows saida=1001111 ("E").
  - TRAP stays in TRAP until reset is asserted.
- Undefined: unrecognised opcode returns to FETCH and state 12 does not exist.

Test Plan:
- reset=0 for 2 edges, then release -> saida=1111110, IRWrite=1, PCWrite=1, AluSrcB=01, ALUOp=00, all else 0.
- opcode=100011 -> state sequence 0,1,2,3,4,0. In state 4: MemtoReg=1, RegWrite=1.
- opcode=101011 -> states 0,1,2,5,0. In state 5: IorD=1, MemWrite=1, saida=1011011.
- opcode=000000 -> states 0,1,6,7,0. In state 6: ALUOp=10, AluSrcA=1. In state 7: RegDst=1, RegWrite=1.
- opcode=000100 then 001000 then 000010:
  - beq: states 0,1,8,0. In state 8: Branch=1, PCSrc=01, ALUOp=01.
  - addi: states 0,1,9,10,0.
  - j: states 0,1,11,0. In state 11: PCSrc=10, PCWrite=1, saida=0011111.
- reset=0 while in MEMRD -> FETCH on the next edge. opcode=111111 -> DECODE goes to FETCH, or to TRAP with saida=1001111 when MIPS_ILLEGAL_TRAP_EN is defined.
